// File: rtl/dbus_pkg.sv
// dbus_pkg: shared definitions for the data bus responder.
//   - I/O page address constants (word aligned)
//   - STATUS register bit positions
//   - address decode selector enum
package dbus_pkg;

    localparam logic [31:0] IO_BASE     = 32'h8000_0000;
    localparam logic [31:0] TXDATA_ADDR = IO_BASE + 32'h0;
    localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'h4;
    localparam logic [31:0] CYCLE_ADDR  = IO_BASE + 32'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TX,
        REG_STATUS,
        REG_CYCLE,
        REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: byte FIFO drained over a valid/ready stream.
// Ports:
//   clk, reset      clock, async active-high reset (clears storage too)
//   push_i          push request; accepted when not full, or when full
//                   and a pop happens on the same edge
//   push_data_i     byte to push
//   full_o/empty_o  occupancy flags
//   count_o         number of stored bytes ($clog2(DEPTH)+1 bits)
//   pop_o           handshake fired this cycle (tx_valid && tx_ready)
//   tx_valid/tx_data/tx_ready  output stream, head byte on tx_data
module tx_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     pop_o,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_acc;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_CNT);
    assign count_o  = count_q;
    assign tx_valid = !empty_o;
    assign tx_data  = mem_q[rd_ptr_q];
    assign pop_o    = tx_valid && tx_ready;
    // When full, the slot freed by a same-edge pop takes the new byte.
    assign push_acc = push_i && (!full_o || pop_o);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_o) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_acc, pop_o})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: responder for the core data-memory port.
// Low address half is word RAM, high half is an I/O page with a byte
// transmit FIFO (TXDATA), a sticky STATUS register and, when the macro
// DBUS_CYCLE_CNT_EN is defined, a loadable free-running CYCLE counter.
// Ports:
//   clk, reset   clock, async active-high reset (RAM contents kept)
//   we, a, wd    Memory-stage write strobe, byte address, write data
//   rd           combinational read data for address a
//   tx_valid, tx_data, tx_ready   transmit byte stream
module data_bus_responder
    import dbus_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e          sel;
    logic [31:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_q [RAM_WORDS];

    logic              fifo_full, fifo_empty, fifo_pop, push_req;
    logic [CNT_W-1:0]  fifo_count;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       status;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^a[1:0];
    assign word_addr        = {a[31:2], 2'b00};
    assign ram_idx          = a[RAM_AW+1:2];

    always_comb begin
        sel = REG_NONE;
        if (!a[31]) begin
            if (a[30:RAM_AW+2] == '0) sel = REG_RAM;
        end else if (word_addr == TXDATA_ADDR) begin
            sel = REG_TX;
        end else if (word_addr == STATUS_ADDR) begin
            sel = REG_STATUS;
`ifdef DBUS_CYCLE_CNT_EN
        end else if (word_addr == CYCLE_ADDR) begin
            sel = REG_CYCLE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we && sel == REG_RAM) ram_q[ram_idx] <= wd;
    end

    assign push_req = we && (sel == REG_TX);

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_req),
        .push_data_i (wd[7:0]),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .pop_o       (fifo_pop),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready)
    );

    // Clear first so a same-edge set event overrides the W1C.
    always_comb begin
        err_d = err_q;
        ovf_d = ovf_q;
        if (we && sel == REG_STATUS) begin
            if (wd[ST_ERR]) err_d = 1'b0;
            if (wd[ST_OVF]) ovf_d = 1'b0;
        end
        if (we && sel == REG_NONE)              err_d = 1'b1;
        if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            err_q <= err_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef DBUS_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (we && sel == REG_CYCLE) cycle_d = wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_d;
    end
`endif

    always_comb begin
        status                        = '0;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_ERR]                = err_q;
        status[ST_OVF]                = ovf_q;
        status[ST_CNT_LSB +: CNT_W]   = fifo_count;
    end

    always_comb begin
        rd = '0;
        case (sel)
            REG_RAM:    rd = ram_q[ram_idx];
            REG_STATUS: rd = status;
`ifdef DBUS_CYCLE_CNT_EN
            REG_CYCLE:  rd = cycle_q;
`endif
            default:    rd = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

    localparam logic [31:0] TX_A  = 32'h8000_0000;
    localparam logic [31:0] ST_A  = 32'h8000_0004;
    localparam logic [31:0] CYC_A = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rd_q [$];
    string       exp_nm_q [$];
    logic [7:0]  exp_tx_q [$];
    logic        rd_chk = 1'b0;

    data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: checks rd whenever a read is flagged, and every stream handshake.
    logic [31:0] mon_v;
    string       mon_n;
    logic [7:0]  mon_b;
    always @(negedge clk) begin
        if (rd_chk) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_queue: read flagged with no expectation, rd=%h", rd);
            end else begin
                mon_v = exp_rd_q.pop_front();
                mon_n = exp_nm_q.pop_front();
                if (rd !== mon_v) begin
                    failures++;
                    $display("FAIL %s: rd=%h expected %h", mon_n, rd, mon_v);
                end
            end
        end
        if (!reset && tx_valid && tx_ready) begin
            checks++;
            if (exp_tx_q.size() == 0) begin
                failures++;
                $display("FAIL tx_queue: unexpected byte %h", tx_data);
            end else begin
                mon_b = exp_tx_q.pop_front();
                if (tx_data !== mon_b) begin
                    failures++;
                    $display("FAIL tx_byte: tx_data=%h expected %h", tx_data, mon_b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        cyc();
        we = 1'b0;
    endtask

    // Write while also checking the same-cycle (pre-write) read value.
    task automatic wr_old(input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] old, input string name);
        exp_rd_q.push_back(old); exp_nm_q.push_back(name);
        rd_chk = 1'b1;
        wr(addr, data);
        rd_chk = 1'b0;
    endtask

    task automatic rdx(input logic [31:0] addr, input logic [31:0] exp, input string name);
        we = 1'b0; a = addr;
        exp_rd_q.push_back(exp); exp_nm_q.push_back(name);
        rd_chk = 1'b1;
        cyc();
        rd_chk = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input logic expect_out);
        wr(TX_A, {24'h0, b});
        if (expect_out) exp_tx_q.push_back(b);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; a = '0; wd = '0; tx_ready = 1'b0;
        cyc(); cyc();
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'b0, tx_data}, 32'h0);
        reset = 1'b0;
        rdx(ST_A, 32'h0000_0002, "reset_status");

        // RAM write / read-after-write / ignored byte offset / same-cycle old value
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rdx(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd_after_wr");
        rdx(32'h0000_0013, 32'hDEAD_BEEF, "ram_byte_offset");
        wr_old(32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF, "ram_same_cycle_old");
        rdx(32'h0000_0010, 32'h1234_5678, "ram_new_value");
        wr(32'h0000_0000, 32'h0BAD_C0DE);
        rdx(TX_A, 32'h0, "txdata_reads_zero");

        // Fill the FIFO with tx_ready low
        push(8'h41, 1'b1);
        chk("push_valid_latency", {31'b0, tx_valid}, 32'h1);
        chk("head_byte", {24'b0, tx_data}, 32'h41);
        for (int i = 1; i < 8; i++) push(8'(8'h41 + i), 1'b1);
        rdx(ST_A, 32'h0000_0801, "status_full");
        chk("head_stable", {24'b0, tx_data}, 32'h41);
        push(8'h5A, 1'b0);
        rdx(ST_A, 32'h0000_0809, "status_ovf");
        wr(ST_A, 32'h0000_0008);
        rdx(ST_A, 32'h0000_0801, "status_ovf_clr");

        // Push while full with simultaneous pop
        tx_ready = 1'b1;
        we = 1'b1; a = TX_A; wd = 32'h49;
        exp_tx_q.push_back(8'h49);
        cyc();
        we = 1'b0; tx_ready = 1'b0;
        rdx(ST_A, 32'h0000_0801, "full_push_pop");
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_valid; i++) cyc();
        chk("drain_done", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        chk("drain_all_bytes", exp_tx_q.size(), 32'h0);
        rdx(ST_A, 32'h0000_0002, "status_empty");

        // Unmapped write sets ERR and does not alias into RAM
        wr(32'h0000_1000, 32'hCAFE_F00D);
        rdx(ST_A, 32'h0000_0006, "status_err");
        rdx(32'h0000_0000, 32'h0BAD_C0DE, "ram_no_alias");
        wr(ST_A, 32'h0000_0004);
        rdx(ST_A, 32'h0000_0002, "status_err_clr");
        rdx(32'h9000_0000, 32'h0, "unmapped_read");
        rdx(ST_A, 32'h0000_0002, "read_no_err");

`ifdef DBUS_CYCLE_CNT_EN
        wr(CYC_A, 32'hFFFF_FFFE);
        rdx(CYC_A, 32'hFFFF_FFFE, "cycle_load");
        rdx(CYC_A, 32'hFFFF_FFFF, "cycle_inc");
        rdx(CYC_A, 32'h0000_0000, "cycle_wrap");
        rdx(ST_A, 32'h0000_0002, "cycle_wr_no_err");
`else
        wr(CYC_A, 32'hFFFF_FFFE);
        rdx(CYC_A, 32'h0, "cycle_absent_read");
        rdx(ST_A, 32'h0000_0006, "cycle_absent_err");
        wr(ST_A, 32'h0000_0004);
`endif

        // Reset mid-transfer
        wr(32'h0000_0020, 32'h55AA_55AA);
        push(8'h61, 1'b0);
        push(8'h62, 1'b0);
        push(8'h63, 1'b0);
        chk("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, tx_valid}, 32'h0);
        chk("async_reset_data", {24'b0, tx_data}, 32'h0);
        cyc();
        reset = 1'b0;
        rdx(ST_A, 32'h0000_0002, "post_reset_status");
        rdx(32'h0000_0020, 32'h55AA_55AA, "ram_kept_20");
        rdx(32'h0000_0010, 32'h1234_5678, "ram_kept_10");

        cyc();
        chk("rd_queue_empty", exp_rd_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
